// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data bits.
package uart_pkg;

  // Transmitter FSM states; the PARITY state only exists in parity builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per line bit (integer division, remainder dropped).
  function automatic int cycles_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts CYCLES_PER_BIT cycles per line bit and strobes
// o_bit_end on the last cycle of each bit. i_restart holds it at zero so the
// first bit after a restart is a full period long.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CNT_W = counter_width(CYCLES_PER_BIT);

  logic [CNT_W-1:0] r_count;

  assign o_bit_end = (r_count == CNT_W'(CYCLES_PER_BIT - 1));

  // Count up within a bit, wrap at the bit end, hold at zero on restart.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    if (reset || i_restart || o_bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_multibyte.sv
// Multi-character UART transmitter. One accepted word is sent as NUM_BYTES
// back-to-back characters: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits.
// Build option: UART_TX_PARITY_EN enables the parity bit (even, or odd when
// PARITY_ODD=1). Without it PARITY_ODD has no effect.
module uart_tx_multibyte
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int NUM_BYTES       = 2,
  parameter int STOP_BITS       = 1,
  parameter int MSB_BYTE_FIRST  = 1,
  parameter int PARITY_ODD      = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_BYTES*DATA_BITS-1:0] data,
  input  logic                           valid,
  output logic                           ready,
  output logic                           q,
  output logic                           busy,
  output logic                           done
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int WORD_BITS      = NUM_BYTES * DATA_BITS;
  localparam int BIT_IDX_W      = counter_width(DATA_BITS);
  localparam int BYTE_IDX_W     = counter_width(NUM_BYTES);

  // Elaboration-time guards on the supported parameter ranges.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_multibyte: DATA_BITS must be 5..9");
  end
  if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bad_num_bytes
    $error("uart_tx_multibyte: NUM_BYTES must be 1..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_multibyte: STOP_BITS must be 1 or 2");
  end
  if (MSB_BYTE_FIRST < 0 || MSB_BYTE_FIRST > 1) begin : g_bad_byte_order
    $error("uart_tx_multibyte: MSB_BYTE_FIRST must be 0 or 1");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_multibyte: PARITY_ODD must be 0 or 1");
  end
  if (CYCLES_PER_BIT < 1) begin : g_bad_rate
    $error("uart_tx_multibyte: BAUD_RATE must not exceed CLOCK_FREQUENCY");
  end

  tx_state_t             r_state;
  logic [WORD_BITS-1:0]  r_data;
  logic [DATA_BITS-1:0]  r_shift;
  logic [BIT_IDX_W-1:0]  r_bit_idx;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic                  r_stop_idx;
  logic                  r_q;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_bit_end;
  logic                  w_restart;
  logic [BYTE_IDX_W-1:0] w_char_sel;
  logic [DATA_BITS-1:0]  w_char;

  assign q     = r_q;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

  // The bit timer is parked in IDLE so the start bit gets a full period.
  assign w_restart = (r_state == ST_IDLE);

  uart_baud_tick #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud_tick (
    .clock    (clock),
    .reset    (reset),
    .i_restart(w_restart),
    .o_bit_end(w_bit_end)
  );

  // Map the send order (byte index) onto the character position in the word.
  assign w_char_sel = (MSB_BYTE_FIRST != 0) ? BYTE_IDX_W'(NUM_BYTES - 1) - r_byte_idx
                                            : r_byte_idx;

  // Pick the character currently being sent out of the latched word.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    w_char = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (BYTE_IDX_W'(i) == w_char_sel) begin
        w_char = r_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic w_parity;
  assign w_parity = (^w_char) ^ (PARITY_ODD != 0);
`endif

  // Frame sequencer: walks start/data/(parity)/stop per character and drives
  // the registered line, handshake and done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_stop_idx <= 1'b0;
      r_q        <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_q <= 1'b1;
          if (valid && r_ready) begin
            r_data     <= data;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_stop_idx <= 1'b0;
            r_q        <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_q       <= w_char[0];
            r_shift   <= w_char >> 1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_q     <= w_parity;
              r_state <= ST_PARITY;
`else
              r_q        <= 1'b1;
              r_stop_idx <= 1'b0;
              r_state    <= ST_STOP;
`endif
            end else begin
              r_q       <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_q        <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop_idx == 1'(STOP_BITS - 1)) begin
              if (r_byte_idx == BYTE_IDX_W'(NUM_BYTES - 1)) begin
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
                r_q        <= 1'b0;
                r_state    <= ST_START;
              end
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_q     <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_multibyte.sv
// Directed bench for uart_tx_multibyte at 16 cycles per bit, two 8-bit
// characters, MSB character first, one stop bit.
module tb_uart_tx_multibyte;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB        = 16;
  localparam int BPC        = 1 + 8 + P + 1;
  localparam int FRAME_BITS = 2 * BPC;
  localparam int W          = FRAME_BITS * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data  = 16'h0000;
  logic        valid = 1'b0;
  logic        ready, q, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  uart_tx_multibyte #(
    .CLOCK_FREQUENCY(16),
    .BAUD_RATE      (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data (data),
    .valid(valid),
    .ready(ready),
    .q    (q),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line bit per bit time: high character first, LSB first inside.
  function automatic logic [63:0] frame_bits(input logic [15:0] w);
    logic [63:0] b;
    logic [7:0]  ch;
    int          k;
    b = '1;
    k = 0;
    for (int n = 0; n < 2; n++) begin
      ch = (n == 0) ? w[15:8] : w[7:0];
      b[k] = 1'b0; k++;
      for (int i = 0; i < 8; i++) begin
        b[k] = ch[i]; k++;
      end
`ifdef UART_TX_PARITY_EN
      b[k] = ^ch; k++;
`endif
      b[k] = 1'b1; k++;
    end
    return b;
  endfunction

  // Called right after the acceptance edge; checks every cycle of the frame
  // and the done cycle. mode 0: drop valid; 1: drop valid, disturb data and
  // re-pulse valid mid-frame; 2: keep valid high and present alt as next word.
  task automatic run_frame(input logic [15:0] word, input string tag, input int mode,
                           input logic [15:0] alt);
    logic [63:0] fb;
    logic        first;
    int          hold_ok, done_hi, rdy_hi, busy_bad, c;
    fb = frame_bits(word);
    first = 1'b0;
    done_hi = 0; rdy_hi = 0; busy_bad = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      hold_ok = 0;
      for (int s = 0; s < CPB; s++) begin
        c = b * CPB + s;
        @(negedge clock);
        if (s == 0) first = q;
        if (q === fb[b]) hold_ok++;
        if (done !== 1'b0) done_hi++;
        if (ready !== 1'b0) rdy_hi++;
        if (busy !== ~ready) busy_bad++;
        case (mode)
          0: if (c == 0) valid = 1'b0;
          1: begin
            if (c == 0) begin valid = 1'b0; data = 16'h0000; end
            if (c == 100) valid = 1'b1;
            if (c == 104) valid = 1'b0;
          end
          default: if (c == 0) data = alt;
        endcase
      end
      check($sformatf("%s_bit%0d", tag, b), {31'd0, first}, {31'd0, fb[b]});
      check($sformatf("%s_hold%0d", tag, b), hold_ok, CPB);
    end
    check({tag, "_done_early"}, done_hi, 0);
    check({tag, "_ready_busy"}, rdy_hi, 0);
    check({tag, "_busy_inv"}, busy_bad, 0);
    @(negedge clock);
    check({tag, "_done_state"}, {28'd0, q, ready, busy, done}, 32'b1101);
  endtask

`ifdef UART_TX_PARITY_EN
  logic       valid_p = 1'b0;
  logic [7:0] data_p  = 8'h00;
  logic       q_pe, rdy_pe, busy_pe, done_pe;
  logic       q_po, rdy_po, busy_po, done_po;

  uart_tx_multibyte #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .NUM_BYTES(1), .PARITY_ODD(0)) dut_pe (
    .clock(clock), .reset(reset), .data(data_p), .valid(valid_p),
    .ready(rdy_pe), .q(q_pe), .busy(busy_pe), .done(done_pe)
  );
  uart_tx_multibyte #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .NUM_BYTES(1), .PARITY_ODD(1)) dut_po (
    .clock(clock), .reset(reset), .data(data_p), .valid(valid_p),
    .ready(rdy_po), .q(q_po), .busy(busy_po), .done(done_po)
  );
`endif

  initial begin
    int q_low, rdy_low, done_hi;

    // Reset held for three cycles.
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("reset_state", {28'd0, q, ready, busy, done}, 32'b1100);
    end
    reset = 1'b0;
    @(negedge clock);
    check("post_reset", {28'd0, q, ready, busy, done}, 32'b1100);

    // Frame 1: A55A, single valid pulse.
    @(negedge clock);
    check("f1_idle_q", {31'd0, q}, 1);
    data = 16'hA55A; valid = 1'b1;
    @(posedge clock);
    run_frame(16'hA55A, "f1", 0, 16'h0000);
    @(negedge clock);
    check("f1_done_pulse", {31'd0, done}, 0);

    // Frame 2: same word, data disturbed and valid re-pulsed while busy.
    data = 16'hA55A; valid = 1'b1;
    @(posedge clock);
    run_frame(16'hA55A, "f2", 1, 16'h0000);
    q_low = 0; rdy_low = 0;
    repeat (40) begin
      @(negedge clock);
      if (q !== 1'b1) q_low++;
      if (ready !== 1'b1) rdy_low++;
    end
    check("f2_no_second_q", q_low, 0);
    check("f2_no_second_rdy", rdy_low, 0);

    // Frames 3/4: valid held high across two words.
    data = 16'h0102; valid = 1'b1;
    @(posedge clock);
    run_frame(16'h0102, "f3", 2, 16'h0304);
    @(posedge clock);
    run_frame(16'h0304, "f4", 0, 16'h0000);
    @(negedge clock);
    check("f4_done_pulse", {31'd0, done}, 0);

    // Reset 100 cycles into an all-zero frame.
    data = 16'h0000; valid = 1'b1;
    @(posedge clock);
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (c == 0) valid = 1'b0;
    end
    check("abort_pre_q", {31'd0, q}, 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_state", {28'd0, q, ready, busy, done}, 32'b1100);
    reset = 1'b0;
    q_low = 0; done_hi = 0;
    repeat (W) begin
      @(negedge clock);
      if (q !== 1'b1) q_low++;
      if (done !== 1'b0) done_hi++;
    end
    check("abort_no_done", done_hi, 0);
    check("abort_idle_q", q_low, 0);

    // Clean frame after the abort.
    data = 16'h3C96; valid = 1'b1;
    @(posedge clock);
    run_frame(16'h3C96, "f5", 0, 16'h0000);

`ifdef UART_TX_PARITY_EN
    // Single 8-bit character 0x07: even parity 1, odd parity 0, 176 cycles.
    @(negedge clock);
    data_p = 8'h07; valid_p = 1'b1;
    @(posedge clock);
    done_hi = 0;
    for (int c = 0; c < 176; c++) begin
      @(negedge clock);
      if (c == 0) valid_p = 1'b0;
      if (c == 9 * CPB + 8) begin
        check("par_even", {31'd0, q_pe}, 1);
        check("par_odd", {31'd0, q_po}, 0);
      end
      if (done_pe !== 1'b0 || done_po !== 1'b0) done_hi++;
    end
    check("par_done_early", done_hi, 0);
    @(negedge clock);
    check("par_done", {30'd0, done_pe, done_po}, 32'b11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_multibyte.md
Name: uart_tx_multibyte

Overview:
Parametrised UART transmitter and successor of the fixed 16-bit / 8N1 transmitter. Sends a word of NUM_BYTES characters back to back, each DATA_BITS wide, with configurable stop bits and optional parity. Uses a valid/ready handshake and latches the word at acceptance. Sits between the debug/packet logic and the board TX pin.

Parameters:
CLOCK_FREQUENCY, 50000000, input clock in Hz
BAUD_RATE, 9600, line rate in bit/s
DATA_BITS, 8, data bits per character (5..9)
NUM_BYTES, 2, characters per accepted word (1..8)
STOP_BITS, 1, stop bits per character (1 or 2)
MSB_BYTE_FIRST, 1, 1 = character [NUM_BYTES*DATA_BITS-1 -: DATA_BITS] sent first; 0 = lowest character first
PARITY_ODD, 0, 0 = even, 1 = odd; used only when UART_TX_PARITY_EN is defined

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
data   input  NUM_BYTES*DATA_BITS  word to send; sampled only on acceptance
valid  input  1  word available
ready  output 1  transmitter idle; acceptance = valid && ready at a rising edge
q      output 1  serial line, idle high; registered
busy   output 1  frame in progress; equals ~ready
done   output 1  one-cycle pulse when the last stop bit of the word completes

Behaviour:
- CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division). Bit counter width is $clog2(CYCLES_PER_BIT). Every line bit is held exactly CYCLES_PER_BIT cycles.
- Reset values: q=1, ready=1, busy=0, done=0, state IDLE, all counters 0. Reset mid-frame aborts the frame: q=1 on the next cycle, no done pulse.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: on acceptance, latch data into the shift register, clear the bit counter and byte index, go to START. q goes low in the cycle after acceptance. ready drops in that same cycle.
- START: q=0 for one bit time, then go to DATA.
- DATA: send DATA_BITS bits, LSB first within each character, then go to PARITY or STOP.
- STOP: q=1 for STOP_BITS bit times.
  - If characters remain: advance the byte index and go to START with no extra gap.
  - After the last character: go to IDLE, with ready=1 and done=1 in that same cycle.
- Word length = NUM_BYTES*(1+DATA_BITS+P+STOP_BITS)*CYCLES_PER_BIT cycles, where P=1 with parity and P=0 without. done occurs exactly that many cycles after the acceptance edge.
- valid asserted while busy is ignored; a changing data input while busy has no effect.
- If valid stays high, the next word is accepted in the first IDLE cycle. This gives exactly one clock of extra idle-high gap between words.
- done and acceptance may fall in the same cycle only if valid is high when ready rises; acceptance takes effect that cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state after DATA drives q = XOR of the character's data bits, inverted if PARITY_ODD=1, for one bit time.
- Undefined: no PARITY state, PARITY_ODD is ignored, and the frame is 1+DATA_BITS+STOP_BITS bits per character.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef (tx_state_t)
  - the function cycles_per_bit(freq, baud)
  - the function counter width via $clog2
- One sub-module, uart_baud_tick: bit-period counter with a synchronous restart input and a bit_end strobe asserted on the last cycle of each bit.
- Shift register, byte index and FSM stay in uart_tx_multibyte.

Test Plan:
- Sim with CLOCK_FREQUENCY=16, BAUD_RATE=1 (16 cycles/bit), defaults otherwise. Reset for 3 cycles -> q=1, ready=1, busy=0, done=0 throughout and after reset.
- valid pulse with data=16'hA55A, no macro -> q sequence per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1 (byte A5), then 0,0,1,0,1,1,0,1,0,1 (byte 5A). done pulses 320 cycles after acceptance; q low exactly 1 cycle after acceptance.
- Same run with data changed to 16'h0000 while busy and valid re-pulsed mid-frame -> waveform identical to the previous case, with no second frame.
- valid held high with two words 16'h0102 then 16'h0304 -> second start bit begins exactly 1 idle cycle after done; ready high for exactly 1 cycle.
- UART_TX_PARITY_EN defined, PARITY_ODD=0, NUM_BYTES=1, data=8'h07 -> parity bit 1, frame 11 bits = 176 cycles. With PARITY_ODD=1 the parity bit is 0.
- Reset asserted 100 cycles into a frame -> q=1 next cycle, ready=1, no done pulse. A new valid then produces a clean full frame.
